// File: rtl/signed_product_accumulator_if.sv
// Product-in / sum-out handshake bundle for signed_product_accumulator.
// The master drives products and takes results; the slave is the accumulator.
interface signed_product_accumulator_if #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_sat;
  logic [7:0]        beat_cnt;

  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, beat_cnt
  );

  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_sat, beat_cnt
  );
endinterface

// File: rtl/signed_product_accumulator.sv
// Sums COUNT signed products with per-beat saturation and holds the result
// on a valid/ready output until consumed; clr aborts any partial or held result.
module signed_product_accumulator #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned COUNT  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  signed_product_accumulator_if.slave  bus
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [7:0]       LAST_BEAT = 8'(COUNT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic             sat_q;
  logic [7:0]       beat_cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_sat_q;

  logic [SUM_W-1:0] prod_ext;
  logic [SUM_W-1:0] sum_wide;
  logic             clamp;
  logic [ACC_W-1:0] acc_d;
  logic             sat_d;
  logic             accept;

  // Saturating add at ACC_W+1 bits; the two top bits differ only on overflow.
  always_comb begin
    prod_ext = {{(SUM_W-PROD_W){bus.in_product[PROD_W-1]}}, bus.in_product};
    sum_wide = {acc_q[ACC_W-1], acc_q} + prod_ext;
    clamp    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    acc_d    = sum_wide[ACC_W-1:0];
    if (clamp) begin
      acc_d = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    sat_d  = sat_q | clamp;
    accept = bus.in_valid && in_ready_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      beat_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      beat_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q      <= prod_ext[ACC_W-1:0];
            sat_q      <= 1'b0;
            beat_cnt_q <= 8'd1;
            if (COUNT == 1) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_sum_q   <= prod_ext[ACC_W-1:0];
              out_sat_q   <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (beat_cnt_q == LAST_BEAT) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_sum_q   <= acc_d;
              out_sat_q   <= sat_d;
            end
          end
        end
        HOLD: begin
          // Result and flags stay frozen under back-pressure; out_sum persists afterwards.
          if (bus.out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          beat_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_signed_product_accumulator.sv
// Bench for signed_product_accumulator: vector table, directed corner sequences
// and a randomized run against an arithmetic reference model (ACC_W 24 and 17).
module tb_signed_product_accumulator;

  localparam int unsigned PROD_W = 16;
  localparam int unsigned COUNT  = 4;

  logic clk;
  logic rst_n;
  logic clr;

  signed_product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(24)) b24 ();
  signed_product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(17)) b17 ();

  signed_product_accumulator #(.PROD_W(PROD_W), .ACC_W(24), .COUNT(COUNT)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(b24)
  );
  signed_product_accumulator #(.PROD_W(PROD_W), .ACC_W(17), .COUNT(COUNT)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(b17)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit sel17;
    int p0, p1, p2, p3;
    int exp_sum;
    bit exp_sat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the selected DUT; the other one is kept idle.
  task automatic drv(input bit sel, input bit v, input int p, input bit r);
    b24.in_valid   = sel ? 1'b0 : v;
    b24.in_product = 16'(p);
    b24.out_ready  = sel ? 1'b1 : r;
    b17.in_valid   = sel ? v : 1'b0;
    b17.in_product = 16'(p);
    b17.out_ready  = sel ? r : 1'b1;
  endtask

  function automatic longint o_sum(input bit sel);
    logic signed [23:0] s24;
    logic signed [16:0] s17;
    s24 = $signed(b24.out_sum);
    s17 = $signed(b17.out_sum);
    return sel ? longint'(s17) : longint'(s24);
  endfunction

  function automatic longint o_valid(input bit sel);
    return sel ? longint'(b17.out_valid) : longint'(b24.out_valid);
  endfunction

  function automatic longint o_sat(input bit sel);
    return sel ? longint'(b17.out_sat) : longint'(b24.out_sat);
  endfunction

  function automatic longint o_rdy(input bit sel);
    return sel ? longint'(b17.in_ready) : longint'(b24.in_ready);
  endfunction

  function automatic longint o_beat(input bit sel);
    return sel ? longint'(b17.beat_cnt) : longint'(b24.beat_cnt);
  endfunction

  task automatic accept_one(input bit sel, input int p);
    drv(sel, 1'b1, p, 1'b0);
    tick();
  endtask

  // Reference: running sum clamped to the signed acc_w range after every beat.
  task automatic model_beat(input int acc_w, input longint p, inout longint sum, inout bit sat);
    longint mx, mn, t;
    mx = (longint'(1) <<< (acc_w - 1)) - 1;
    mn = -(longint'(1) <<< (acc_w - 1));
    t  = sum + p;
    if (t > mx) begin sum = mx; sat = 1'b1; end
    else if (t < mn) begin sum = mn; sat = 1'b1; end
    else sum = t;
  endtask

  task automatic random_run(input bit sel, input int cycles);
    bit      hold = 0;
    int      cnt  = 0;
    longint  msum = 0;
    bit      msat = 0;
    int      acc_w;
    acc_w = sel ? 17 : 24;
    for (int i = 0; i < cycles; i++) begin
      bit          v, r, c;
      logic [15:0] raw;
      int          p;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: raw = 16'h7fff;
        1: raw = 16'h8000;
        default: raw = 16'($urandom);
      endcase
      p = int'($signed(raw));
      clr = c;
      drv(sel, v, p, r);
      tick();
      if (c) begin
        hold = 0; cnt = 0; msat = 0; msum = 0;
      end else if (hold) begin
        if (r) begin hold = 0; cnt = 0; end
      end else if (v) begin
        if (cnt == 0) begin msum = p; msat = 0; end
        else model_beat(acc_w, p, msum, msat);
        cnt++;
        if (cnt == COUNT) hold = 1;
      end
      chk("rand out_valid", o_valid(sel), longint'(hold));
      chk("rand in_ready", o_rdy(sel), longint'(!hold));
      chk("rand beat_cnt", o_beat(sel), longint'(cnt));
      if (hold) begin
        chk("rand out_sum", o_sum(sel), msum);
        chk("rand out_sat", o_sat(sel), longint'(msat));
      end
    end
    clr = 1'b0;
    drv(sel, 1'b0, 0, 1'b1);
    tick();
    chk("rand drained", o_valid(sel), 0);
  endtask

  initial begin
    vecs[0] = '{1'b0,    100,   -200,    300,    -50,     150, 1'b0};
    vecs[1] = '{1'b0, -32768, -32768, -32768, -32768, -131072, 1'b0};
    vecs[2] = '{1'b0,  32767, -32768,      1,      0,       0, 1'b0};
    vecs[3] = '{1'b0,      0,      0,      0,      0,       0, 1'b0};
    vecs[4] = '{1'b1,  32767,  32767,  32767,  32767,   65535, 1'b1};
    vecs[5] = '{1'b1, -32768, -32768, -32768, -32768,  -65536, 1'b1};
    vecs[6] = '{1'b1,  32767,  32767, -32768, -32768,      -2, 1'b0};
    vecs[7] = '{1'b1,  32767,  32767,  32767, -32768,   32767, 1'b1};

    clk   = 1'b0;
    rst_n = 1'b0;
    clr   = 1'b0;
    drv(1'b0, 1'b0, 0, 1'b1);
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("reset out_valid", o_valid(s[0]), 0);
      chk("reset out_sum", o_sum(s[0]), 0);
      chk("reset out_sat", o_sat(s[0]), 0);
      chk("reset beat_cnt", o_beat(s[0]), 0);
      chk("reset in_ready", o_rdy(s[0]), 1);
    end
    #5 rst_n = 1'b1;
    tick();

    // Back-to-back vectors, including ACC_W=17 saturation cases.
    for (int i = 0; i < 8; i++) begin
      bit sel;
      sel = vecs[i].sel17;
      accept_one(sel, vecs[i].p0);
      chk("vec beat1", o_beat(sel), 1);
      accept_one(sel, vecs[i].p1);
      accept_one(sel, vecs[i].p2);
      accept_one(sel, vecs[i].p3);
      chk("vec out_valid", o_valid(sel), 1);
      chk("vec out_sum", o_sum(sel), vecs[i].exp_sum);
      chk("vec out_sat", o_sat(sel), longint'(vecs[i].exp_sat));
      drv(sel, 1'b0, 0, 1'b1);
      tick();
      chk("vec out_valid drop", o_valid(sel), 0);
    end

    // Bubbles between beats, then 5 cycles of back-pressure with in_valid ignored.
    for (int k = 1; k <= 4; k++) begin
      accept_one(1'b0, k);
      chk("bubble beat_cnt", o_beat(1'b0), k);
      drv(1'b0, 1'b0, 99, 1'b0);
      tick();
      chk("bubble beat hold", o_beat(1'b0), k);
    end
    for (int k = 0; k < 5; k++) begin
      drv(1'b0, 1'b1, 1000, 1'b0);
      tick();
      chk("bp out_valid", o_valid(1'b0), 1);
      chk("bp out_sum", o_sum(1'b0), 10);
      chk("bp in_ready", o_rdy(1'b0), 0);
    end
    drv(1'b0, 1'b0, 0, 1'b1);
    tick();
    chk("bp out_valid drop", o_valid(1'b0), 0);
    chk("bp beat_cnt clear", o_beat(1'b0), 0);
    chk("bp out_sum kept", o_sum(1'b0), 10);

    // clr with a product presented aborts the partial sum and drops that product.
    accept_one(1'b0, 7);
    accept_one(1'b0, 9);
    clr = 1'b1;
    drv(1'b0, 1'b1, 5, 1'b0);
    tick();
    clr = 1'b0;
    chk("clr beat_cnt", o_beat(1'b0), 0);
    chk("clr in_ready", o_rdy(1'b0), 1);
    for (int k = 1; k <= 4; k++) accept_one(1'b0, k);
    chk("clr then sum", o_sum(1'b0), 10);
    chk("clr then valid", o_valid(1'b0), 1);

    // Async reset while holding a result.
    drv(1'b0, 1'b0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", o_valid(1'b0), 0);
    chk("async rst out_sum", o_sum(1'b0), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post rst in_ready", o_rdy(1'b0), 1);

    // A product offered on the output-handshake cycle is taken only in IDLE.
    for (int k = 0; k < 4; k++) accept_one(1'b0, 3);
    chk("hs out_valid", o_valid(1'b0), 1);
    drv(1'b0, 1'b1, 42, 1'b1);
    tick();
    chk("hs not taken", o_beat(1'b0), 0);
    chk("hs out_valid drop", o_valid(1'b0), 0);
    tick();
    chk("hs taken next", o_beat(1'b0), 1);
    for (int k = 0; k < 3; k++) accept_one(1'b0, 1);
    chk("hs sum", o_sum(1'b0), 45);
    drv(1'b0, 1'b0, 0, 1'b1);
    tick();

    random_run(1'b0, 400);
    random_run(1'b1, 400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
